// File: rtl/dot_product_row_scheduler.sv
// Streams NROWS matrix rows plus the vector through the dot-product unit in zero-padded NI-lane beats, one result per row.
// Beat period is 4 cycles plus I_am_ready wait; rows stall on a finish rising edge. ROW_TIMEOUT_EN adds a WAIT_FIN timeout.
module dot_product_row_scheduler #(
    parameter int NOE    = 10,
    parameter int NI     = 8,
    parameter int NROWS  = 4,
    parameter int ADDR_W = 8
`ifdef ROW_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mat_rd_en,
    output logic [ADDR_W-1:0]   mat_rd_addr,
    input  logic [32*NI-1:0]    mat_rd_data,
    output logic [ADDR_W-1:0]   vec_rd_addr,
    input  logic [32*NI-1:0]    vec_rd_data,
    output logic [32*NI-1:0]    first_row_input,
    output logic [32*NI-1:0]    second_row_input,
    output logic                outsider_read_now,
    output logic [31:0]         no_of_multiples,
    input  logic                I_am_ready,
    input  logic                finish,
    input  logic [31:0]         dot_product_output,
    output logic [31:0]         result_data,
    output logic [ADDR_W-1:0]   result_row,
    output logic                result_valid
`ifdef ROW_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    localparam int B = (NOE + NI - 1) / NI;
    localparam logic [ADDR_W-1:0] B_LAST   = ADDR_W'(B - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(NROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT_RDY,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  row, beat;
    logic               finish_q;
    logic               fin_edge;
    logic               tmo_hit;
    logic               row_end;
    logic [32*NI-1:0]   mat_masked, vec_masked;

    assign fin_edge        = finish & ~finish_q;
    assign row_end         = (state == S_WAIT_FIN) && (fin_edge || tmo_hit);
    assign no_of_multiples = 32'(B);
    assign mat_rd_addr     = ADDR_W'(int'(row) * B + int'(beat));
    assign vec_rd_addr     = beat;

    // Lanes past the end of the row read as zero so the pad contributes nothing to the sum.
    always_comb begin
        mat_masked = '0;
        vec_masked = '0;
        for (int k = 0; k < NI; k++) begin
            if (int'(beat) * NI + k < NOE) begin
                mat_masked[32*(NI-k)-1 -: 32] = mat_rd_data[32*(NI-k)-1 -: 32];
                vec_masked[32*(NI-k)-1 -: 32] = vec_rd_data[32*(NI-k)-1 -: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        busy              = 1'b1;
        done              = 1'b0;
        mat_rd_en         = 1'b0;
        outsider_read_now = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mat_rd_en = 1'b1;
                state_nxt = S_LOAD;
            end
            S_LOAD:  state_nxt = S_ISSUE;
            S_ISSUE: begin
                outsider_read_now = 1'b1;
                state_nxt         = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (I_am_ready) state_nxt = (beat == B_LAST) ? S_WAIT_FIN : S_FETCH;
            end
            S_WAIT_FIN: begin
                if (row_end) state_nxt = (row == ROW_LAST) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row              <= '0;
            beat             <= '0;
            finish_q         <= 1'b0;
            first_row_input  <= '0;
            second_row_input <= '0;
            result_data      <= '0;
            result_row       <= '0;
            result_valid     <= 1'b0;
        end else begin
            // Edge detector runs in every state so a level held across rows never looks like a new edge.
            finish_q     <= finish;
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row  <= '0;
                        beat <= '0;
                    end
                end
                S_LOAD: begin
                    first_row_input  <= mat_masked;
                    second_row_input <= vec_masked;
                end
                S_WAIT_RDY: begin
                    if (I_am_ready && beat != B_LAST) beat <= beat + ADDR_W'(1);
                end
                S_WAIT_FIN: begin
                    if (row_end) begin
                        result_data  <= fin_edge ? dot_product_output : 32'hFFFF_FFFF;
                        result_row   <= row;
                        result_valid <= 1'b1;
                        if (row != ROW_LAST) begin
                            row  <= row + ADDR_W'(1);
                            beat <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ROW_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == S_WAIT_FIN) && !fin_edge && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != S_WAIT_FIN || row_end) tmo_cnt <= '0;
            else                                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_row_scheduler.sv
// Randomized matrix-vector runs against a scoreboard of expected row dot products, with a unit model that checks beat operands.
module tb_dot_product_row_scheduler;

    localparam int NOE    = 10;
    localparam int NI     = 8;
    localparam int NROWS  = 4;
    localparam int ADDR_W = 8;
    localparam int B      = (NOE + NI - 1) / NI;
    localparam int W      = 32 * NI;

    logic              clk;
    logic              reset;
    logic              start;
    logic              busy, done;
    logic              mat_rd_en;
    logic [ADDR_W-1:0] mat_rd_addr, vec_rd_addr;
    logic [W-1:0]      mat_rd_data, vec_rd_data;
    logic [W-1:0]      first_row_input, second_row_input;
    logic              outsider_read_now;
    logic [31:0]       no_of_multiples;
    logic              I_am_ready, finish;
    logic [31:0]       dot_product_output;
    logic [31:0]       result_data;
    logic [ADDR_W-1:0] result_row;
    logic              result_valid;
`ifdef ROW_TIMEOUT_EN
    logic              timeout_err;
`endif

    dot_product_row_scheduler #(
        .NOE(NOE), .NI(NI), .NROWS(NROWS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mat_rd_en(mat_rd_en), .mat_rd_addr(mat_rd_addr), .mat_rd_data(mat_rd_data),
        .vec_rd_addr(vec_rd_addr), .vec_rd_data(vec_rd_data),
        .first_row_input(first_row_input), .second_row_input(second_row_input),
        .outsider_read_now(outsider_read_now), .no_of_multiples(no_of_multiples),
        .I_am_ready(I_am_ready), .finish(finish), .dot_product_output(dot_product_output),
        .result_data(result_data), .result_row(result_row), .result_valid(result_valid)
`ifdef ROW_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Element-level model of the buffers; elements past NOE hold garbage that must never reach a sum.
    logic [31:0] mat_el [NROWS][B*NI];
    logic [31:0] vec_el [B*NI];

    function automatic logic [W-1:0] beat_of(input int r, input int b, input bit is_vec, input bit masked);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < NI; k++) begin
            if (!masked || b * NI + k < NOE)
                v[32*(NI-k)-1 -: 32] = is_vec ? vec_el[b*NI+k] : mat_el[r][b*NI+k];
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_dot(input int r);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < NOE; k++) s = s + mat_el[r][k] * vec_el[k];
        return s;
    endfunction

    task automatic fill_mem();
        for (int r = 0; r < NROWS; r++)
            for (int k = 0; k < B * NI; k++) mat_el[r][k] = $urandom;
        for (int k = 0; k < B * NI; k++) vec_el[k] = $urandom;
    endtask

    // One-cycle-latency RAMs: address seen this cycle, data valid from just after the next edge.
    initial begin : ram_model
        bit                en_s;
        logic [ADDR_W-1:0] ma, va;
        mat_rd_data = '0;
        vec_rd_data = '0;
        forever begin
            @(negedge clk);
            en_s = mat_rd_en;
            ma   = mat_rd_addr;
            va   = vec_rd_addr;
            @(posedge clk);
            #1;
            if (en_s) mat_rd_data = (int'(ma) < NROWS * B) ? beat_of(int'(ma) / B, int'(ma) % B, 1'b0, 1'b0) : '0;
            vec_rd_data = (int'(va) < B) ? beat_of(0, int'(va), 1'b1, 1'b0) : '0;
        end
    end

    // Dot-product unit model.
    bit          long_rdy = 0;
    bit          hold_fin = 0;
    int          u_row = 0, u_beat = 0, rdy_wait = 0, fin_wait = 0;
    bit          pending = 0, fin_pend = 0;
    logic [31:0] acc = '0, u_result = '0;

    initial begin : unit_model
        I_am_ready         = 1'b0;
        finish             = 1'b0;
        dot_product_output = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                I_am_ready = 1'b0;
                finish     = 1'b0;
                pending    = 0;
                fin_pend   = 0;
                u_row      = 0;
                u_beat     = 0;
                acc        = '0;
                continue;
            end
            I_am_ready = !pending && ($urandom_range(0, 3) == 0);
            if (pending) begin
                if (rdy_wait == 0) begin
                    I_am_ready = 1'b1;
                    pending    = 0;
                    u_beat++;
                    if (u_beat == B) begin
                        u_beat   = 0;
                        u_row++;
                        u_result = acc;
                        acc      = '0;
                        fin_pend = 1;
                        fin_wait = $urandom_range(1, 5);
                    end
                end else begin
                    rdy_wait--;
                end
            end
            if (fin_pend) begin
                if (fin_wait > 0) begin
                    fin_wait--;
                end else if (finish) begin
                    finish   = 1'b0;
                    fin_wait = 2;
                end else begin
                    finish             = 1'b1;
                    dot_product_output = u_result;
                    fin_pend           = 0;
                end
            end
            if (outsider_read_now) begin
                if (u_row >= NROWS) u_row = 0;
                chk("strobe_while_beat_pending", W'(pending), '0);
                chk("op_mat", first_row_input, beat_of(u_row, u_beat, 1'b0, 1'b1));
                chk("op_vec", second_row_input, beat_of(0, u_beat, 1'b1, 1'b1));
                for (int k = 0; k < NI; k++)
                    acc = acc + first_row_input[32*(NI-k)-1 -: 32] * second_row_input[32*(NI-k)-1 -: 32];
                if (u_beat == 0 && !hold_fin) finish = 1'b0;
                pending  = 1;
                rdy_wait = (long_rdy && u_beat == 0) ? 20 : int'($urandom_range(0, 4));
            end
        end
    end

    // Scoreboard monitor.
    typedef struct {
        logic [31:0] data;
        int          row;
    } res_t;
    res_t sb_q[$];
    int   addr_q[$];
    int   done_cnt = 0;

    initial begin : monitor
        res_t e;
        int   a;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (result_valid) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got row %0d data %h, none expected", result_row, result_data);
                    end else begin
                        e = sb_q.pop_front();
                        chk("result_data", W'(result_data), W'(e.data));
                        chk("result_row", W'(result_row), W'(e.row));
                    end
                end
                if (mat_rd_en) begin
                    if (addr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_fetch: got addr %0d, none expected", mat_rd_addr);
                    end else begin
                        a = addr_q.pop_front();
                        chk("mat_rd_addr", W'(mat_rd_addr), W'(a));
                        chk("vec_rd_addr", W'(vec_rd_addr), W'(a % B));
                    end
                end
                if (done) begin
                    chk("results_before_done", W'(sb_q.size()), '0);
                    chk("busy_at_done", W'(busy), '0);
                    done_cnt++;
                end
            end
        end
    end

    task automatic launch();
        res_t e;
        for (int r = 0; r < NROWS; r++) begin
            e.data = exp_dot(r);
            e.row  = r;
            sb_q.push_back(e);
            for (int b = 0; b < B; b++) addr_q.push_back(r * B + b);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (done_cnt >= target) break;
        end
        chk("run_complete", W'(done_cnt), W'(target));
        @(negedge clk);
        chk("busy_after_done", W'(busy), '0);
        chk("queue_drained", W'(sb_q.size() + addr_q.size()), '0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, W'(busy), '0);
        chk({tag, "_done"}, W'(done), '0);
        chk({tag, "_mat_rd_en"}, W'(mat_rd_en), '0);
        chk({tag, "_read_now"}, W'(outsider_read_now), '0);
        chk({tag, "_result_valid"}, W'(result_valid), '0);
        chk({tag, "_first_row"}, first_row_input, '0);
        chk({tag, "_second_row"}, second_row_input, '0);
        chk({tag, "_result_data"}, W'(result_data), '0);
    endtask

    initial begin : driver
        int runs = 0;
        reset = 1'b1;
        start = 1'b0;
        fill_mem();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        chk("no_of_multiples", W'(no_of_multiples), W'(B));
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        fill_mem();
        launch();
        wait_done(++runs);

        fill_mem();
        long_rdy = 1;
        launch();
        wait_done(++runs);
        long_rdy = 0;

        fill_mem();
        hold_fin = 1;
        launch();
        wait_done(++runs);
        hold_fin = 0;

        // Stray starts during an active run must not restart or duplicate it.
        fill_mem();
        launch();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(++runs);

        // Reset while row 2 waits for ready, then a clean run.
        fill_mem();
        long_rdy = 1;
        launch();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (u_row == 2 && pending) break;
        end
        chk("reached_row2_wait", W'(u_row == 2 && pending), W'(1));
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_outputs_zero("midrun_reset");
        sb_q.delete();
        addr_q.delete();
        repeat (3) @(negedge clk);
        chk("no_done_after_reset", W'(done_cnt), W'(runs));
        reset    = 1'b1;
        long_rdy = 0;
        repeat (2) @(negedge clk);
        fill_mem();
        launch();
        wait_done(++runs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
